// File: rtl/pe_pkg.sv
// Shared encodings for the PE convolution engine: packet opcodes, FSM states and
// helpers that locate packet fields inside {dest, src, op, data}.
package pe_pkg;

    typedef enum logic [1:0] {
        OpFilt  = 2'b00,
        OpSpike = 2'b01,
        OpPsum  = 2'b10,
        OpStart = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCompute = 2'b01,
        StSend    = 2'b10
    } state_e;

    function automatic int unsigned op_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned src_lsb(input int unsigned data_w);
        return data_w + 2;
    endfunction

    function automatic int unsigned dest_lsb(input int unsigned addr_w, input int unsigned data_w);
        return data_w + 2 + addr_w;
    endfunction

endpackage

// File: rtl/pe_mac.sv
// Single-tap multiply-accumulate: adds weight when the spike bit is set and
// saturates at the top of the psum range.
module pe_mac #(
    parameter int unsigned W_W    = 8,
    parameter int unsigned PSUM_W = 8
) (
    input  logic [PSUM_W-1:0] acc,
    input  logic              spike,
    input  logic [W_W-1:0]    weight,
    output logic [PSUM_W-1:0] sum
);

    localparam int unsigned SUM_W = ((PSUM_W > W_W) ? PSUM_W : W_W) + 1;
    localparam logic [SUM_W-1:0] PSUM_MAX = SUM_W'({PSUM_W{1'b1}});

    logic [SUM_W-1:0] wide;

    always_comb begin
        wide = SUM_W'(acc) + (spike ? SUM_W'(weight) : '0);
        sum  = (wide > PSUM_MAX) ? '1 : wide[PSUM_W-1:0];
    end

endmodule

// File: rtl/pe_conv_engine.sv
// 1-D spike convolution PE: loads filter/spikes/psum over packets, computes one tap per
// cycle and emits one psum packet per position. `PE_SPIKE_OUT_EN adds a threshold spike bit.
module pe_conv_engine
    import pe_pkg::*;
#(
    parameter int unsigned PE_IDX    = 1,
    parameter int unsigned PSUM_DEST = 0,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned FILT_LEN  = 3,
    parameter int unsigned SPIKE_LEN = 5,
    parameter int unsigned W_W       = 8,
    parameter int unsigned PSUM_W    = 8,
`ifdef PE_SPIKE_OUT_EN
    parameter int unsigned THRESH    = 4,
`endif
    parameter int unsigned DATA_W    = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*ADDR_W+2+DATA_W-1:0] in_packet,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*ADDR_W+2+DATA_W-1:0] out_packet,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned NOUT     = SPIKE_LEN - FILT_LEN + 1;
    localparam int unsigned IDX_W    = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int unsigned K_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned SI_W     = (SPIKE_LEN > 1) ? $clog2(SPIKE_LEN) : 1;
    localparam int unsigned OP_LSB   = op_lsb(DATA_W);
    localparam int unsigned SRC_LSB  = src_lsb(DATA_W);
    localparam int unsigned DEST_LSB = dest_lsb(ADDR_W, DATA_W);
    localparam logic [IDX_W-1:0] LAST_O = IDX_W'(NOUT - 1);
    localparam logic [K_W-1:0]   LAST_K = K_W'(FILT_LEN - 1);

    state_e state_q, state_d;

    logic [FILT_LEN-1:0][W_W-1:0] filt_q;
    logic [SPIKE_LEN-1:0]         spk_q;
    logic [NOUT-1:0][PSUM_W-1:0]  psum_buf_q;
    logic                         filt_ok_q, spk_ok_q;
    logic [PSUM_W-1:0]            acc_q;
    logic [IDX_W-1:0]             o_q;
    logic [K_W-1:0]               k_q;
    logic                         err_q, err_d;

    logic [DATA_W-1:0] in_data;
    op_e               in_op;
    logic [IDX_W-1:0]  in_idx;
    logic              dest_hit, in_fire, start_ok;
    logic [SI_W-1:0]   spk_idx;
    logic [PSUM_W-1:0] mac_sum;
    logic [DATA_W-1:0] out_data;
    logic              unused_src;

    assign in_data    = in_packet[DATA_W-1:0];
    assign in_op      = op_e'(in_packet[OP_LSB +: 2]);
    assign in_idx     = in_data[PSUM_W +: IDX_W];
    assign dest_hit   = in_packet[DEST_LSB +: ADDR_W] == ADDR_W'(PE_IDX);
    assign unused_src = ^in_packet[SRC_LSB +: ADDR_W];

    // Ready is forced low for the whole time reset is held.
    assign in_ready  = (state_q == StIdle) && !reset;
    assign in_fire   = in_valid && in_ready;
    assign start_ok  = filt_ok_q && spk_ok_q;
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StSend);
    assign err       = err_q;
    assign spk_idx   = SI_W'(o_q) + SI_W'(k_q);

    pe_mac #(
        .W_W    (W_W),
        .PSUM_W (PSUM_W)
    ) u_mac (
        .acc    (acc_q),
        .spike  (spk_q[spk_idx]),
        .weight (filt_q[k_q]),
        .sum    (mac_sum)
    );

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_fire) begin
                    if (!dest_hit) begin
                        err_d = 1'b1;
                    end else if (in_op == OpStart) begin
                        if (start_ok) state_d = StCompute;
                        else          err_d   = 1'b1;
                    end
                end
            end
            StCompute: if (k_q == LAST_K) state_d = StSend;
            StSend:    if (out_ready) state_d = (o_q == LAST_O) ? StIdle : StCompute;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q     <= '0;
            spk_q      <= '0;
            psum_buf_q <= '0;
            filt_ok_q  <= 1'b0;
            spk_ok_q   <= 1'b0;
            acc_q      <= '0;
            o_q        <= '0;
            k_q        <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                StIdle: begin
                    if (in_fire && dest_hit) begin
                        unique case (in_op)
                            OpFilt: begin
                                filt_q    <= in_data[FILT_LEN*W_W-1:0];
                                filt_ok_q <= 1'b1;
                            end
                            OpSpike: begin
                                spk_q    <= in_data[SPIKE_LEN-1:0];
                                spk_ok_q <= 1'b1;
                            end
                            OpPsum: begin
                                if (32'(in_idx) < NOUT) psum_buf_q[in_idx] <= in_data[PSUM_W-1:0];
                            end
                            OpStart: begin
                                if (start_ok) begin
                                    o_q   <= '0;
                                    k_q   <= '0;
                                    acc_q <= psum_buf_q[0];
                                end
                            end
                        endcase
                    end
                end
                StCompute: begin
                    acc_q <= mac_sum;
                    k_q   <= (k_q == LAST_K) ? '0 : k_q + K_W'(1);
                end
                StSend: begin
                    if (out_ready) begin
                        if (o_q == LAST_O) begin
                            // Run complete: the filter stays, spikes and psum inputs are consumed.
                            spk_ok_q   <= 1'b0;
                            psum_buf_q <= '0;
                        end else begin
                            o_q   <= o_q + IDX_W'(1);
                            k_q   <= '0;
                            acc_q <= psum_buf_q[o_q + IDX_W'(1)];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        out_data[PSUM_W +: IDX_W] = o_q;
`ifdef PE_SPIKE_OUT_EN
        if (32'(acc_q) >= THRESH) begin
            out_data[IDX_W+PSUM_W]  = 1'b1;
            out_data[PSUM_W-1:0]    = acc_q - PSUM_W'(THRESH);
        end else begin
            out_data[PSUM_W-1:0]    = acc_q;
        end
`else
        out_data[PSUM_W-1:0] = acc_q;
`endif
        out_packet = '0;
        if (out_valid) begin
            out_packet = {ADDR_W'(PSUM_DEST), ADDR_W'(PE_IDX), OpPsum, out_data};
        end
    end

endmodule

// File: tb/tb_pe_conv_engine.sv
// Scoreboard bench for pe_conv_engine: a reference model pushes expected packets at start,
// the output monitor pops and compares them on each out handshake.
module tb_pe_conv_engine;

    localparam int NOUT = 3;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready;
    logic [33:0] in_packet;
    logic        out_valid, out_ready;
    logic [33:0] out_packet;
    logic        busy, err;

    int n_checks = 0;
    int n_fail   = 0;
    int out_count = 0;
    logic [63:0] exp_q[$];

    int m_filt[3];
    bit m_spk[5];
    int m_psum[NOUT];

    pe_conv_engine dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_packet  (in_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() > 0) check("out_pkt", 64'(out_packet), exp_q.pop_front());
        end
    end

    function automatic logic [63:0] exp_pkt(input int o);
        int acc;
        logic [23:0] d;
        logic [63:0] p;
        acc = m_psum[o];
        for (int k = 0; k < 3; k++) begin
            if (m_spk[o+k]) begin
                acc += m_filt[k];
                if (acc > 255) acc = 255;
            end
        end
        d = '0;
        d[9:8] = 2'(o);
        d[7:0] = 8'(acc);
`ifdef PE_SPIKE_OUT_EN
        if (acc >= 4) begin
            d[10]  = 1'b1;
            d[7:0] = 8'(acc - 4);
        end
`endif
        p = {30'd0, 4'd0, 4'd1, 2'b10, d};
        return p;
    endfunction

    task automatic send(input logic [3:0] dest, input logic [1:0] op, input logic [23:0] data);
        int n;
        n = 0;
        in_packet = {dest, 4'd7, op, data};
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_filter(input int a, input int b, input int c);
        send(4'd1, 2'b00, {8'(c), 8'(b), 8'(a)});
        m_filt[0] = a;
        m_filt[1] = b;
        m_filt[2] = c;
    endtask

    task automatic load_spk(input logic [4:0] s);
        send(4'd1, 2'b01, {19'd0, s});
        for (int i = 0; i < 5; i++) m_spk[i] = s[i];
    endtask

    task automatic load_psum(input int idx, input int v);
        send(4'd1, 2'b10, {14'd0, 2'(idx), 8'(v)});
        m_psum[idx] = v;
    endtask

    task automatic do_run(input bit chk_lat, input bit hold);
        int n, base, hold_base;
        bit stable;
        logic [33:0] cap;
        base = out_count;
        for (int o = 0; o < NOUT; o++) exp_q.push_back(exp_pkt(o));
        for (int o = 0; o < NOUT; o++) m_psum[o] = 0;
        if (hold) out_ready = 1'b0;
        send(4'd1, 2'b11, 24'd0);
        @(negedge clk);
        check("busy_run", 64'(busy), 64'd1);
        check("in_ready_run", 64'(in_ready), 64'd0);
        n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (chk_lat) check("first_valid_cycle", 64'(n), 64'd4);
        if (hold) begin
            cap = out_packet;
            hold_base = out_count;
            stable = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (out_packet !== cap || out_valid !== 1'b1) stable = 1'b0;
            end
            check("hold_stable", 64'(stable), 64'd1);
            check("hold_no_extra", 64'(out_count - hold_base), 64'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("run_done", 64'(busy), 64'd0);
        check("out_count", 64'(out_count - base), 64'(NOUT));
        @(posedge clk);
        #1;
    endtask

    task automatic start_reject(input string tag);
        int base;
        base = out_count;
        send(4'd1, 2'b11, 24'd0);
        @(negedge clk);
        check({tag, "_err"}, 64'(err), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_err_clear"}, 64'(err), 64'd0);
        repeat (8) @(negedge clk);
        check({tag, "_no_out"}, 64'(out_count - base), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_packet = '0;
        out_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_packet", 64'(out_packet), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Saturation: psum_in 200 plus full-scale taps
        load_filter(255, 255, 255);
        @(negedge clk);
        check("load_no_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        load_spk(5'b11111);
        load_psum(0, 200);
        do_run(1'b0, 1'b0);

        // Basic run with latency check; psum buffer must have been cleared
        load_filter(1, 2, 3);
        load_spk(5'b10110);
        do_run(1'b1, 1'b0);

        // Filter kept across runs, psum_in on the last position
        load_spk(5'b10110);
        load_psum(2, 10);
        do_run(1'b0, 1'b0);

        // Spike frame consumed by the previous run
        start_reject("no_spk");

        // Foreign destination: consumed with err, no state change
        send(4'd2, 2'b00, 24'h090909);
        @(negedge clk);
        check("dest2_err", 64'(err), 64'd1);
        @(posedge clk);
        #1;
        send(4'd2, 2'b11, 24'd0);
        @(negedge clk);
        check("dest2_start_err", 64'(err), 64'd1);
        check("dest2_start_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Back-pressure while in SEND, filter still {1,2,3}
        load_spk(5'b11010);
        do_run(1'b0, 1'b1);

        // Reset during COMPUTE abandons the run and clears the filter
        load_spk(5'b11111);
        base = out_count;
        send(4'd1, 2'b11, 24'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 64'(in_ready), 64'd1);
        repeat (10) @(negedge clk);
        check("midrst_no_out", 64'(out_count - base), 64'd0);
        @(posedge clk);
        #1;
        load_spk(5'b01010);
        start_reject("filt_cleared");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
